// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder stage.
package fft_pkg;
  localparam int unsigned DW    = 34;
  localparam int unsigned N     = 16;
  localparam int unsigned LOG2N = 4;

  // One complex sample as emitted by the core: imag in the upper half.
  typedef struct packed {
    logic [16:0] im;
    logic [16:0] re;
  } sample_t;

  // Reverse the LOG2N-bit index.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      r[i] = x[LOG2N-1-i];
    end
    return r;
  endfunction
endpackage

// File: rtl/fft_out_reorder_if.sv
// Sample stream handshakes in (bit-reversed) and out (natural order).
interface fft_out_reorder_if;
  import fft_pkg::*;

  logic    in_valid;
  logic    in_sof;
  sample_t in_data;
  logic    in_ready;
  logic    out_valid;
  logic    out_ready;
  sample_t out_data;
  logic    out_last;
  logic    frame_err;

  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, frame_err
  );

  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, frame_err
  );
endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank register array: one synchronous write port, one asynchronous read port.
module fft_pingpong_ram
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             i_we,
  input  logic             i_wbank,
  input  logic [LOG2N-1:0] i_waddr,
  input  sample_t          i_wdata,
  input  logic             i_rbank,
  input  logic [LOG2N-1:0] i_raddr,
  output sample_t          o_rdata
);
  sample_t r_mem [2][N];

  // Store an accepted sample into the selected bank.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wbank][i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_rbank][i_raddr];
endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: writes frames at bit-reversed addresses and
// replays them in natural index order.
module fft_out_reorder
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,  // active-high synchronous reset
  fft_out_reorder_if.slave   io
);
  logic [1:0]       r_full;
  logic             r_wbank;
  logic             r_rbank;
  logic [LOG2N-1:0] r_wcnt;
  logic [LOG2N-1:0] r_rcnt;
  logic             r_frame_err;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_acc;
  logic             w_xfer;
  logic [LOG2N-1:0] w_widx;
  logic             w_wdone;
  logic             w_rdone;
  logic             w_sync_err;
  sample_t          w_rdata;

  assign w_in_ready  = !rst_n && !r_full[r_wbank];
  assign w_out_valid = !rst_n && r_full[r_rbank];
  assign w_acc       = io.in_valid && w_in_ready;
  assign w_xfer      = w_out_valid && io.out_ready;

  // A sof restarts the frame, so the sample's index becomes 0 regardless of wcnt.
  assign w_widx      = io.in_sof ? '0 : r_wcnt;
  assign w_wdone     = w_acc && (w_widx == LOG2N'(N-1));
  assign w_rdone     = w_xfer && (r_rcnt == LOG2N'(N-1));
  assign w_sync_err  = io.in_sof ? (r_wcnt != '0) : (r_wcnt == '0);

  fft_pingpong_ram u_ram (
    .clk     (clk),
    .i_we    (w_acc),
    .i_wbank (r_wbank),
    .i_waddr (bitrev(w_widx)),
    .i_wdata (io.in_data),
    .i_rbank (r_rbank),
    .i_raddr (r_rcnt),
    .o_rdata (w_rdata)
  );

  // Write/read counters, bank selects, bank-full flags and sync-error pulse.
  // Set and clear of r_full always hit different banks: a bank being written
  // is empty while the bank being read is full.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_full      <= '0;
      r_wbank     <= 1'b0;
      r_rbank     <= 1'b0;
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_acc && w_sync_err;
      if (w_acc) begin
        r_wcnt <= w_widx + 1'b1;
      end
      if (w_wdone) begin
        r_full[r_wbank] <= 1'b1;
        r_wbank         <= ~r_wbank;
      end
      if (w_xfer) begin
        r_rcnt <= r_rcnt + 1'b1;
      end
      if (w_rdone) begin
        r_full[r_rbank] <= 1'b0;
        r_rbank         <= ~r_rbank;
      end
    end
  end

  assign io.in_ready  = w_in_ready;
  assign io.out_valid = w_out_valid;
  assign io.out_data  = w_out_valid ? w_rdata : '0;
  assign io.out_last  = w_out_valid && (r_rcnt == LOG2N'(N-1));
  assign io.frame_err = r_frame_err;
endmodule

// File: tb/tb_fft_out_reorder.sv
// Randomized bench for fft_out_reorder against a frame-level reference model.
module tb_fft_out_reorder;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_out_reorder_if ifc ();

  fft_out_reorder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ifc.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: frame assembly buffer in natural order, output queue,
  // number of complete frames still buffered, expected sync-error pulse.
  logic [DW-1:0] fr [N];
  logic [DW-1:0] qd [$];
  bit            ql [$];
  int            pos     = 0;
  int            pending = 0;
  bit            exp_err = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rev(input int x);
    int r = 0;
    int v = x;
    for (int i = 0; i < int'(LOG2N); i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom(), $urandom()});
  endfunction

  // One clock cycle: drive, check against model, advance model, clock.
  task automatic step(input bit rst, input bit v, input bit sof, input logic [DW-1:0] d,
                      input bit ordy, output bit acc);
    bit eir, eov, xfer;
    rst_n         = rst;
    ifc.in_valid  = v;
    ifc.in_sof    = sof;
    ifc.in_data   = d;
    ifc.out_ready = ordy;
    #2;
    eir = !rst && (pending < 2);
    eov = !rst && (pending > 0);
    chk("in_ready", ifc.in_ready, eir);
    chk("out_valid", ifc.out_valid, eov);
    if (rst) chk("rst_out_data", ifc.out_data, '0);
    else     chk("frame_err", ifc.frame_err, exp_err);
    if (eov) begin
      if (qd.size() == 0) chk("model_queue", 1, 0);
      else begin
        chk("out_data", ifc.out_data, qd[0]);
        chk("out_last", ifc.out_last, ql[0]);
      end
    end
    acc  = v && eir;
    xfer = eov && ordy && (qd.size() > 0);
    exp_err = 1'b0;
    if (rst) begin
      qd.delete();
      ql.delete();
      pending = 0;
      pos     = 0;
    end else begin
      if (xfer) begin
        if (ql[0]) pending--;
        void'(qd.pop_front());
        void'(ql.pop_front());
      end
      if (acc) begin
        if (sof && pos != 0) begin
          exp_err = 1'b1;
          pos     = 0;
        end else if (!sof && pos == 0) begin
          exp_err = 1'b1;
        end
        fr[rev(pos)] = d;
        pos++;
        if (pos == int'(N)) begin
          for (int n = 0; n < int'(N); n++) begin
            qd.push_back(fr[n]);
            ql.push_back(n == int'(N) - 1);
          end
          pending++;
          pos = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer one sample until accepted; mode 0/1 fixed out_ready, 2 random.
  task automatic send(input bit sof, input logic [DW-1:0] d, input int mode);
    bit acc;
    int n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      step(0, 1, sof, d, (mode == 2) ? bit'($urandom_range(0, 1)) : bit'(mode), acc);
      n++;
    end
    if (!acc) chk("send_timeout", 1, 0);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while (qd.size() > 0 && n < 500) begin
      step(0, 0, 0, '0, 1, acc);
      n++;
    end
    chk("drained", qd.size(), 0);
    step(0, 0, 0, '0, 1, acc);
  endtask

  initial begin
    bit acc;
    rst_n = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_sof    = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b0;
    @(negedge clk);
    step(1, 0, 0, '0, 0, acc);
    step(1, 0, 0, '0, 0, acc);

    // Single frame, bit-reversed ramp.
    for (int k = 0; k < 16; k++) send(k == 0, DW'(rev(k)), 1);
    drain();

    // Four back-to-back frames.
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 16; k++) send(k == 0, DW'(f * 16 + rev(k)), 1);
    drain();

    // Backpressure: fill both banks, then try one more.
    for (int k = 0; k < 32; k++) send(k % 16 == 0, DW'((k / 16) * 16 + rev(k % 16)), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, DW'(99), 0, acc);
    drain();

    // Random out_ready, random data, ten frames.
    for (int f = 0; f < 10; f++)
      for (int k = 0; k < 16; k++) send(k == 0, rnd(), 2);
    drain();

    // Sync error: sof on the 6th sample restarts the frame.
    for (int k = 0; k < 5; k++) send(k == 0, rnd(), 1);
    send(1, rnd(), 1);
    for (int k = 1; k < 16; k++) send(0, rnd(), 1);
    drain();

    // Missing sof on the first sample of a frame.
    for (int k = 0; k < 16; k++) send(0, rnd(), 2);
    drain();

    // Mid-frame reset after nine samples, then a clean frame.
    for (int k = 0; k < 9; k++) send(k == 0, rnd(), 1);
    step(1, 0, 0, '0, 1, acc);
    step(0, 0, 0, '0, 1, acc);
    for (int k = 0; k < 16; k++) send(k == 0, DW'(rev(k) + 100), 2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
Output reorder stage directly downstream of the FFT core's parallel-to-serial output. The core emits 34-bit complex samples (imag [33:17], real [16:0]) in bit-reversed index order. This block holds them in a ping-pong buffer of two N-entry banks and replays each frame in natural index order. Handshakes are valid/ready on both sides, with a frame-start marker, last-sample flag and error flag.

Parameters:
DW, 34, sample width (17-bit imag : 17-bit real)
N, 16, FFT points per frame
LOG2N, 4, index width (log2 of N)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-high (asserted = 1) despite the name
in_valid  input  1  in_data holds a sample
in_sof  input  1  qualifies first sample of a frame (bit-reversed index 0); sampled only when in_valid
in_data  input  DW  sample from FFT core, bit-reversed order
in_ready  output  1  block can accept a sample this cycle
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_data  output  DW  sample, natural order
out_last  output  1  marks natural index N-1
frame_err  output  1  one-cycle pulse on a frame-sync error

Behaviour:
- Storage: two banks, mem[2][N] of DW bits. Per-bank flag full[b].
- Write-side state: wbank (1b), wcnt (LOG2N).
- Read-side state: rbank (1b), rcnt (LOG2N).
- Reset (rst_n=1 at a clock edge) sets full[*], wbank, rbank, wcnt, rcnt, out_data, out_last and frame_err to 0. in_ready and out_valid are 0 during any cycle in which rst_n=1.
- After reset: in_ready = !full[wbank]. out_valid = full[rbank].
- Input acceptance: a sample is accepted when in_valid && in_ready.
  - Write address = bitrev(wcnt), i.e. LOG2N bits reversed. mem[wbank][addr] <= in_data.
  - wcnt increments on each accept.
  - On accepting wcnt==N-1: set full[wbank], toggle wbank, wcnt wraps to 0.
- Frame sync:
  - Accepted sample with in_sof=1 while wcnt!=0: partial frame is discarded. wcnt restarts, and this sample is written at bit-reversed index 0. frame_err pulses 1 the next cycle.
  - Accepted sample with in_sof=0 while wcnt==0: the sample is still written. frame_err pulses.
  - Core output is never stalled by missing sof.
- Output side:
  - out_data = mem[rbank][rcnt] and out_last = (rcnt==N-1). Both are driven combinationally from the register array and are valid whenever out_valid=1.
  - Transfer occurs when out_valid && out_ready: rcnt increments.
  - On transferring rcnt==N-1: clear full[rbank], toggle rbank, rcnt wraps to 0.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- Latency: the edge that accepts the last sample of a frame sets full. out_valid=1 in the following cycle with natural index 0.
- Throughput: 1 sample/cycle sustained when out_ready=1. One bank fills while the other drains.
- Simultaneous events:
  - When the read side frees a bank in the same cycle the write side fills the other, both updates apply.
  - full[] set and clear never target the same bank in the same cycle, because the banks differ by construction.
- Full condition: both banks full → in_ready=0 until the read side releases a bank. in_ready may rise the cycle after the final out_ready handshake.
- Reset mid-frame: all buffered data is discarded (flags cleared, contents don't-care). The next accepted sample is treated as wcnt=0.

Decomposition:
- Shared package fft_pkg:
  - DW, N, LOG2N
  - sample typedef (struct: imag[16:0], real[16:0])
  - bitrev function (LOG2N-bit reverse)
- One natural sub-module: fft_pingpong_ram, holding the two-bank register array with one write port and one asynchronous read port.
- Control counters and flags stay in fft_out_reorder.

Test Plan:
- Reset then single frame: drive 16 samples with in_data = bitrev(k) for k=0..15 (in_sof on first), out_ready=1 → out_data 0,1,…,15 on consecutive cycles. First out_valid comes 1 cycle after last input. out_last only with 15.
- Back-to-back frames: 4 frames, continuous in_valid, values frame*16+bitrev(k), out_ready=1 → natural-order 0..63 output, in_ready never drops.
- Backpressure: out_ready=0 while 2 frames are written → in_ready=0 after 32nd accept; out_data holds 0. Release out_ready → 32 in-order outputs, then in_ready=1.
- Random out_ready (50%): 10 frames → output sequence equals natural order of every frame, no loss or duplication, out_data stable while stalled.
- Sync error: in_sof asserted at 6th sample of a frame → frame_err pulses once. The frame restarting at that sample outputs correctly; the partial frame is never output.
- Mid-frame reset: rst_n=1 for 1 cycle after 9 samples → out_valid=0, in_ready=1 next cycle. A subsequent full frame outputs correctly.
